// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions used by the branch target buffer.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    localparam logic [1:0] CTR_MIN    = 2'b00;
    localparam logic [1:0] CTR_WEAK_T = 2'b10;
    localparam logic [1:0] CTR_MAX    = 2'b11;

    // One BTB way. The tag field is sized for the smallest legal set count;
    // unused upper bits are stored as zero.
    typedef struct packed {
        logic      valid;
        lc3b_word  tag;
        lc3b_word  target;
        logic [1:0] ctr;
    } btb_entry_t;

    // Two-bit saturating direction counter step.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
        end else begin
            return (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
        end
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set. Node i has children 2i+1 / 2i+2; a node bit
// of 0 steers the victim search left, 1 steers it right.
module plru_tree #(
    parameter int unsigned WAYS = 4,
    localparam int unsigned LW  = $clog2(WAYS)
) (
    input  logic [WAYS-2:0] bits,
    input  logic [LW-1:0]   access_way,
    output logic [LW-1:0]   victim,
    output logic [WAYS-2:0] next_bits
);

    // Follow the node bits from the root down to the victim leaf.
    always_comb begin
        int unsigned pos;
        logic [LW-1:0] nd;
        pos = 0;
        nd  = '0;
        for (int unsigned l = 0; l < LW; l++) begin
            nd  = LW'((1 << l) - 1 + pos);
            pos = (pos << 1) + (bits[nd] ? 1 : 0);
        end
        victim = LW'(pos);
    end

    // Point every node on the accessed way's path away from that way.
    always_comb begin
        int unsigned dir;
        int unsigned pfx;
        logic [LW-1:0] nd;
        next_bits = bits;
        nd        = '0;
        for (int unsigned l = 0; l < LW; l++) begin
            pfx = int'(access_way) >> (LW - l);
            dir = (int'(access_way) >> (LW - 1 - l)) & 1;
            nd  = LW'((1 << l) - 1 + pfx);
            next_bits[nd] = (dir == 0);
        end
    end

endmodule

// File: rtl/btb_pred.sv
// Set-associative branch target buffer with 2-bit direction counters and
// tree-PLRU replacement. Lookup is registered (one cycle latency) and always
// reads the array state from before the same-cycle update or flush.
module btb_pred
    import lc3b_types::*;
#(
    parameter int unsigned WAYS = 4,
    parameter int unsigned SETS = 32
) (
    input  logic     clk,
    input  logic     reset,
    input  lc3b_word lk_pc,
    input  logic     lk_valid,
    output logic     pred_hit,
    output logic     pred_taken,
    output lc3b_word pred_target,
    input  logic     upd_valid,
    input  lc3b_word upd_pc,
    input  lc3b_word upd_target,
    input  logic     upd_taken,
    input  logic     flush
);

    localparam int unsigned IB = $clog2(SETS);
    localparam int unsigned LW = $clog2(WAYS);

    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-2:0] plru_q  [SETS];
    lc3b_word        tag_q   [SETS][WAYS];
    lc3b_word        tgt_q   [SETS][WAYS];
    logic [1:0]      ctr_q   [SETS][WAYS];

    logic [IB-1:0] lk_idx;
    lc3b_word      lk_tag;
    logic [IB-1:0] u_idx;
    lc3b_word      u_tag;

    assign lk_idx = lk_pc[IB:1];
    assign lk_tag = lk_pc >> (IB + 1);
    assign u_idx  = upd_pc[IB:1];
    assign u_tag  = upd_pc >> (IB + 1);

    logic       lk_hit;
    logic [1:0] lk_ctr;
    lc3b_word   lk_tgt;

    // Lookup tag compare; a hit needs exactly one matching valid way.
    always_comb begin
        btb_entry_t ent;
        int unsigned n;
        ent    = '0;
        n      = 0;
        lk_ctr = '0;
        lk_tgt = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            ent.valid  = valid_q[lk_idx][LW'(w)];
            ent.tag    = tag_q[lk_idx][LW'(w)];
            ent.target = tgt_q[lk_idx][LW'(w)];
            ent.ctr    = ctr_q[lk_idx][LW'(w)];
            if (ent.valid && ent.tag == lk_tag) begin
                n      = n + 1;
                lk_ctr = ent.ctr;
                lk_tgt = ent.target;
            end
        end
        lk_hit = (n == 1);
    end

    logic          u_hit;
    logic [LW-1:0] u_hit_way;
    logic          u_any_free;
    logic [LW-1:0] u_free_way;
    logic [LW-1:0] u_way;
    logic [LW-1:0] plru_victim;
    logic [WAYS-2:0] plru_next;
    logic [1:0]    u_ctr_new;

    // Update-side match and lowest-index free way search.
    always_comb begin
        btb_entry_t ent;
        int unsigned n;
        ent        = '0;
        n          = 0;
        u_hit_way  = '0;
        u_any_free = 1'b0;
        u_free_way = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            ent.valid = valid_q[u_idx][LW'(w)];
            ent.tag   = tag_q[u_idx][LW'(w)];
            if (!ent.valid) begin
                u_any_free = 1'b1;
                u_free_way = LW'(w);
            end
            if (ent.valid && ent.tag == u_tag) begin
                n         = n + 1;
                u_hit_way = LW'(w);
            end
        end
        u_hit = (n == 1);
    end

    // Hits update in place; misses fill a free way first, else the PLRU victim.
    always_comb begin
        u_way     = u_hit ? u_hit_way : (u_any_free ? u_free_way : plru_victim);
        u_ctr_new = ctr_step(ctr_q[u_idx][u_way], upd_taken);
    end

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits       (plru_q[u_idx]),
        .access_way (u_way),
        .victim     (plru_victim),
        .next_bits  (plru_next)
    );

    logic upd_write;
    assign upd_write = upd_valid && (u_hit || upd_taken);

    // Valid bits and PLRU state: reset, then flush, then update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[IB'(s)] <= '0;
                plru_q[IB'(s)]  <= '0;
            end
        end else if (flush) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[IB'(s)] <= '0;
            end
        end else if (upd_write) begin
            valid_q[u_idx][u_way] <= 1'b1;
            plru_q[u_idx]         <= plru_next;
        end
    end

    // Tag, target and counter storage; no reset needed since valid gates use.
    always_ff @(posedge clk) begin
        if (!reset && !flush && upd_write) begin
            if (u_hit) begin
                ctr_q[u_idx][u_way] <= u_ctr_new;
                if (upd_taken) begin
                    tgt_q[u_idx][u_way] <= upd_target;
                end
            end else begin
                tag_q[u_idx][u_way] <= u_tag;
                tgt_q[u_idx][u_way] <= upd_target;
                ctr_q[u_idx][u_way] <= CTR_WEAK_T;
            end
        end
    end

    // Registered prediction outputs, zero when no lookup or on miss.
    always_ff @(posedge clk) begin
        if (reset || !lk_valid) begin
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else begin
            pred_hit    <= lk_hit;
            pred_taken  <= lk_hit && lk_ctr[1];
            pred_target <= lk_hit ? lk_tgt : '0;
        end
    end

endmodule

// File: tb/tb_btb_pred.sv
// Self-checking bench for btb_pred: directed vector table, a PLRU sequence,
// and randomized traffic against a behavioural BTB model.
module tb_btb_pred;

    localparam int WAYS = 4;
    localparam int SETS = 32;

    logic        clk;
    logic        reset;
    logic [15:0] lk_pc;
    logic        lk_valid;
    logic        pred_hit;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        upd_taken;
    logic        flush;

    btb_pred #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk         (clk),
        .reset       (reset),
        .lk_pc       (lk_pc),
        .lk_valid    (lk_valid),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: each entry remembers the full branch PC; two PCs
    // alias to the same entry when pc[15:1] agree (index plus tag).
    bit          m_valid [SETS][WAYS];
    logic [15:0] m_pc    [SETS][WAYS];
    logic [15:0] m_tgt   [SETS][WAYS];
    int          m_ctr   [SETS][WAYS];
    bit          m_tree  [SETS][WAYS-1];
    bit          e_hit;
    bit          e_taken;
    logic [15:0] e_tgt;

    function automatic int m_set(logic [15:0] pc);
        return int'(pc >> 1) % SETS;
    endfunction

    function automatic int m_find(logic [15:0] pc);
        int s, hits, way;
        s = m_set(pc);
        hits = 0;
        way = -1;
        for (int i = 0; i < WAYS; i++) begin
            if (m_valid[s][i] && (m_pc[s][i] >> 1) == (pc >> 1)) begin
                hits++;
                way = i;
            end
        end
        return (hits == 1) ? way : -1;
    endfunction

    // Binary search over way ranges; the node flag says which half is older.
    function automatic int m_victim(int s);
        int lo, hi, mid, n;
        lo = 0; hi = WAYS; n = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (!m_tree[s][n]) begin hi = mid; n = 2 * n + 1; end
            else               begin lo = mid; n = 2 * n + 2; end
        end
        return lo;
    endfunction

    task automatic m_touch(int s, int w);
        int lo, hi, mid, n;
        lo = 0; hi = WAYS; n = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (w < mid) begin m_tree[s][n] = 1; hi = mid; n = 2 * n + 1; end
            else         begin m_tree[s][n] = 0; lo = mid; n = 2 * n + 2; end
        end
    endtask

    task automatic m_clear(bit also_tree);
        for (int s = 0; s < SETS; s++) begin
            for (int i = 0; i < WAYS; i++) m_valid[s][i] = 0;
            if (also_tree) for (int i = 0; i < WAYS - 1; i++) m_tree[s][i] = 0;
        end
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        int s, w;
        e_hit = 0; e_taken = 0; e_tgt = 16'h0;
        if (reset) begin
            m_clear(1);
        end else begin
            if (lk_valid) begin
                w = m_find(lk_pc);
                if (w >= 0) begin
                    s = m_set(lk_pc);
                    e_hit = 1;
                    e_taken = (m_ctr[s][w] >= 2);
                    e_tgt = m_tgt[s][w];
                end
            end
            if (flush) begin
                m_clear(0);
            end else if (upd_valid) begin
                s = m_set(upd_pc);
                w = m_find(upd_pc);
                if (w >= 0) begin
                    if (upd_taken) begin
                        if (m_ctr[s][w] < 3) m_ctr[s][w]++;
                        m_tgt[s][w] = upd_target;
                    end else if (m_ctr[s][w] > 0) begin
                        m_ctr[s][w]--;
                    end
                    m_touch(s, w);
                end else if (upd_taken) begin
                    for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
                    if (w < 0) w = m_victim(s);
                    m_valid[s][w] = 1;
                    m_pc[s][w] = upd_pc;
                    m_tgt[s][w] = upd_target;
                    m_ctr[s][w] = 2;
                    m_touch(s, w);
                end
            end
        end
    endtask

    task automatic apply(bit rst, bit lkv, logic [15:0] lpc, bit uv,
                         logic [15:0] upc, logic [15:0] utg, bit utk, bit fl);
        reset = rst; lk_valid = lkv; lk_pc = lpc; upd_valid = uv;
        upd_pc = upc; upd_target = utg; upd_taken = utk; flush = fl;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check3(string tag, bit eh, bit et, logic [15:0] eg);
        check({tag, ".hit"},    {15'h0, pred_hit},   {15'h0, eh});
        check({tag, ".taken"},  {15'h0, pred_taken}, {15'h0, et});
        check({tag, ".target"}, pred_target,         eg);
    endtask

    typedef struct {
        bit          rst;
        bit          lkv;
        logic [15:0] lkpc;
        bit          uv;
        logic [15:0] upc;
        logic [15:0] utg;
        bit          utk;
        bit          fl;
        bit          eh;
        bit          et;
        logic [15:0] eg;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [15:0] rnd_pc();
        return 16'(($urandom_range(0, 7) << 6) | ($urandom_range(0, 3) << 1) | $urandom_range(0, 1));
    endfunction

    initial begin
        reset = 1; lk_valid = 0; lk_pc = 0; upd_valid = 0; upd_pc = 0;
        upd_target = 0; upd_taken = 0; flush = 0;

        //            rst lkv lkpc      uv  upc       utg       utk fl  eh et eg
        tbl.push_back('{1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000});
        tbl.push_back('{1, 1, 16'h3000, 1, 16'h3000, 16'h3080, 1, 1, 0, 0, 16'h0000});
        tbl.push_back('{0, 1, 16'h3000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h0000, 1, 16'h3000, 16'h3080, 1, 0, 0, 0, 16'h0000});
        tbl.push_back('{0, 1, 16'h3000, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h3080});
        tbl.push_back('{0, 1, 16'h3000, 1, 16'h3000, 16'h0000, 0, 0, 1, 1, 16'h3080});
        tbl.push_back('{0, 0, 16'h0000, 1, 16'h3000, 16'h0000, 0, 0, 0, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h0000, 1, 16'h3000, 16'h0000, 0, 0, 0, 0, 16'h0000});
        tbl.push_back('{0, 1, 16'h3000, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h3080});
        tbl.push_back('{0, 1, 16'h3000, 1, 16'h3000, 16'h3100, 1, 0, 1, 0, 16'h3080});
        tbl.push_back('{0, 1, 16'h3000, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h3100});
        tbl.push_back('{0, 1, 16'h3000, 1, 16'h3000, 16'h3200, 1, 0, 1, 0, 16'h3100});
        tbl.push_back('{0, 1, 16'h3000, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h3200});
        tbl.push_back('{0, 0, 16'h0000, 1, 16'h0002, 16'h1002, 1, 0, 0, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h0000, 1, 16'h0042, 16'h1042, 1, 0, 0, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h0000, 1, 16'h0082, 16'h1082, 1, 0, 0, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h0000, 1, 16'h00C2, 16'h10C2, 1, 0, 0, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h0000, 1, 16'h0102, 16'h1102, 1, 0, 0, 0, 16'h0000});
        tbl.push_back('{0, 1, 16'h0002, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000});
        tbl.push_back('{0, 1, 16'h0042, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h1042});
        tbl.push_back('{0, 1, 16'h0082, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h1082});
        tbl.push_back('{0, 1, 16'h00C2, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h10C2});
        tbl.push_back('{0, 1, 16'h0102, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h1102});
        tbl.push_back('{0, 1, 16'h0042, 1, 16'h3000, 16'h3300, 1, 1, 1, 1, 16'h1042});
        tbl.push_back('{0, 1, 16'h0042, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000});
        tbl.push_back('{0, 1, 16'h0102, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000});
        tbl.push_back('{0, 1, 16'h3000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h0000, 1, 16'h0042, 16'h2000, 1, 0, 0, 0, 16'h0000});
        tbl.push_back('{0, 1, 16'h0042, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h2000});
        tbl.push_back('{1, 1, 16'h0042, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000});
        tbl.push_back('{0, 1, 16'h0042, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000});
        tbl.push_back('{0, 0, 16'h0000, 1, 16'h0500, 16'h0600, 0, 0, 0, 0, 16'h0000});
        tbl.push_back('{0, 1, 16'h0500, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000});

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].lkv, tbl[i].lkpc, tbl[i].uv,
                  tbl[i].upc, tbl[i].utg, tbl[i].utk, tbl[i].fl);
            check3($sformatf("vec%0d", i), tbl[i].eh, tbl[i].et, tbl[i].eg);
        end

        // Fill set 2, re-touch way 0, then a fifth PC must evict way 2.
        apply(0, 0, 16'h0, 1, 16'h0004, 16'h4004, 1, 0);
        apply(0, 0, 16'h0, 1, 16'h0044, 16'h4044, 1, 0);
        apply(0, 0, 16'h0, 1, 16'h0084, 16'h4084, 1, 0);
        apply(0, 0, 16'h0, 1, 16'h00C4, 16'h40C4, 1, 0);
        apply(0, 0, 16'h0, 1, 16'h0004, 16'h4004, 1, 0);
        apply(0, 0, 16'h0, 1, 16'h0104, 16'h4104, 1, 0);
        apply(0, 1, 16'h0084, 0, 16'h0, 16'h0, 0, 0);
        check3("plru_evict", 0, 0, 16'h0000);
        apply(0, 1, 16'h0004, 0, 16'h0, 16'h0, 0, 0);
        check3("plru_keep_mru", 1, 1, 16'h4004);
        apply(0, 1, 16'h0104, 0, 16'h0, 16'h0, 0, 0);
        check3("plru_new", 1, 1, 16'h4104);

        // Randomized traffic on a small PC pool to force conflicts and aliasing.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] lp, up;
            lp = rnd_pc();
            up = ($urandom_range(0, 3) == 0) ? lp : rnd_pc();
            apply(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1, lp,
                  $urandom_range(0, 2) != 0, up, 16'($urandom),
                  $urandom_range(0, 2) != 0, ($urandom_range(0, 79) == 0));
            check3($sformatf("rnd%0d", i), e_hit, e_taken, e_tgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/btb_pred.md
BTB_PRED -- requirements
Module: btb_pred

Interface
REQ-001 The block SHALL take parameter WAYS, default 4, associativity; power of two, 2..8.
REQ-002 The block SHALL take parameter SETS, default 32, set count; power of two, 4..256.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset (ports below).
REQ-004 The block SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port lk_pc, input, 16, lookup PC (ID stage).
REQ-007 The block SHALL have port lk_valid, input, 1, lookup request this cycle.
REQ-008 The block SHALL have port pred_hit, output, 1, registered: lookup hit.
REQ-009 The block SHALL have port pred_taken, output, 1, registered: hit and counter predicts taken.
REQ-010 The block SHALL have port pred_target, output, 16, registered: stored target on hit, else 0.
REQ-011 The block SHALL have port upd_valid, input, 1, resolved-branch update (WB stage).
REQ-012 The block SHALL have port upd_pc, input, 16, PC of the resolved branch.
REQ-013 The block SHALL have port upd_target, input, 16, resolved target address.
REQ-014 The block SHALL have port upd_taken, input, 1, resolved direction.
REQ-015 The block SHALL have port flush, input, 1, invalidate all entries.

Function
REQ-016 Index SHALL be pc[IB:1], IB=log2(SETS); tag SHALL be pc[15:IB+1].
REQ-017 Each entry SHALL hold valid, tag, 16-bit target and a 2-bit saturating counter; each set SHALL hold WAYS-1 tree-PLRU bits.
REQ-018 Lookup latency SHALL be one cycle: outputs register the result of lk_pc at the edge where lk_valid=1; with lk_valid=0 all outputs register 0.
REQ-019 Hit SHALL mean exactly one valid way with matching tag; pred_taken SHALL equal counter[1] of that way.
REQ-020 Update hit SHALL increment the counter if upd_taken (saturating at 3), else decrement (saturating at 0), SHALL write upd_target only if upd_taken, and SHALL mark the way MRU in PLRU.
REQ-021 Update miss with upd_taken=1 SHALL allocate: victim is the lowest-index invalid way, else the PLRU victim; write valid=1, tag, target, counter=2; mark it MRU.
REQ-022 Update miss with upd_taken=0 SHALL change no state.
REQ-023 Lookups SHALL NOT modify PLRU or counters.
REQ-024 When lookup and update hit the same entry in one cycle, the lookup SHALL return pre-update contents (read-before-write).
REQ-025 flush SHALL clear every valid bit in one cycle; it takes priority over a same-cycle update, which is dropped; the same-cycle lookup returns pre-flush contents.
REQ-026 Target/tag storage SHALL NOT require reset; only valid, PLRU and outputs are reset.

Reset
REQ-027 While reset=1: all valid bits 0, all PLRU bits 0, counters don't-care; pred_hit=0, pred_taken=0, pred_target=0 on the next edge.
REQ-028 Reset SHALL override flush, update and lookup in the same cycle; the first lookup after reset deasserts SHALL miss.

Structure
REQ-029 A shared-package struct btb_entry_t (valid, tag, target, ctr) and the counter constants CTR_WEAK_T=2'b10 and CTR_MAX=2'b11 SHALL live in lc3b_types; lc3b_word SHALL be used for all 16-bit ports.
REQ-030 Tree-PLRU victim select and update SHALL be one sub-module, plru_tree #(WAYS), with a purely combinational victim output and a next-state output.

Verification
REQ-031 After reset, lookup 0x3000 -> pred_hit=0, pred_target=0 next cycle.
REQ-032 Taken update 0x3000->0x3080, then lookup 0x3000 -> pred_hit=1, pred_taken=1 (ctr=2), pred_target=0x3080.
REQ-033 Three not-taken updates on 0x3000 -> ctr=0, pred_taken=0, pred_hit=1; taken update to 0x3100 -> ctr=1, target 0x3100, pred_taken=0.
REQ-034 WAYS=4, SETS=32: taken updates to 5 PCs sharing index 1 (0x0002,0x0042,0x0082,0x00C2,0x0102) -> 0x0002 is evicted and misses; the other 4 hit.
REQ-035 Same-cycle lookup and taken update of new target on a hit entry -> old target this result, new target on the next lookup.
REQ-036 flush with 4 valid entries -> all lookups miss; reset asserted mid-run -> misses, and outputs are 0.
